// File: rtl/iq_tx_nco.sv
// iq_tx_nco: burst-mode numerically controlled oscillator on clk1.
// Produces the cos (I) / sin (Q) reference pair for the I/Q mixer and an
// amplitude-scaled DA transmit sample. Bursts span an integer number of
// carrier cycles; a cycle ends where the phase accumulator wraps.
// Pipeline: address reg -> ROM reg -> sign/mirror reg (I/Q valid),
// then multiply reg -> saturate reg (DA valid).
// Optional feature: define PHASE_DITHER_EN to add LFSR dither into the
// truncated phase bits ahead of the LUT lookup.
module iq_tx_nco #(
   parameter int PHASE_W = 32,
   parameter int LUT_AW  = 8
) (
   input  logic               clk1,
   input  logic               rst,
   input  logic               sample_en,
   input  logic [PHASE_W-1:0] freq_word,
   input  logic [15:0]        amp,
   input  logic [23:0]        burst_cycles,
   input  logic               start,
   input  logic               stop,
   output logic [15:0]        ipcm_out,
   output logic [15:0]        qpcm_out,
   output logic               iqpcm_valid,
   output logic [15:0]        da_pcm_out,
   output logic               da_pcm_valid,
   output logic               busy,
   input  logic               err_clr,
   output logic [1:0]         err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam int LUT_N   = 2 ** LUT_AW;
   localparam int TRUNC_W = PHASE_W - 2 - LUT_AW;

   // Quarter-wave sample k, centred half a step into its bin so no code is 0.
   function automatic logic [15:0] lut_val(input int k);
      real x;
      real term;
      real acc;
      x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(LUT_N);
      term = x;
      acc  = x;
      for (int n = 1; n < 12; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      return 16'($rtoi(32767.0 * acc + 0.5));
   endfunction

   // ------------------------------------------------------------------
   // Quarter-wave ROM contents
   // ------------------------------------------------------------------
   logic [15:0] lut_rom [LUT_N];

   genvar gi;
   generate
      for (gi = 0; gi < LUT_N; gi++) begin : g_lut
         assign lut_rom[gi] = lut_val(gi);
      end
   endgenerate

   // ------------------------------------------------------------------
   // Burst control
   // ------------------------------------------------------------------
   logic [1:0]         state_reg, state_next;
   logic [PHASE_W-1:0] acc_reg, acc_next;
   logic [PHASE_W-1:0] freq_l_reg, freq_l_next;
   logic [23:0]        bc_l_reg, bc_l_next;
   logic [23:0]        cyc_cnt_reg, cyc_cnt_next;
   logic [1:0]         err_reg, err_next;
   logic [PHASE_W:0]   acc_sum;
   logic [23:0]        cyc_inc;
   logic               active;
   logic               step;
   logic               wrap;
   logic               bad_freq;
   logic [1:0]         err_set;

   assign acc_sum  = {1'b0, acc_reg} + {1'b0, freq_l_reg};
   assign wrap     = acc_sum[PHASE_W];
   assign cyc_inc  = cyc_cnt_reg + 24'd1;
   assign active   = (state_reg != ST_IDLE);
   assign step     = active && sample_en;
   assign bad_freq = (freq_word == '0) || freq_word[PHASE_W-1];

   // Next-state, accumulator stepping and error detection.
   always_comb begin
      state_next   = state_reg;
      acc_next     = acc_reg;
      freq_l_next  = freq_l_reg;
      bc_l_next    = bc_l_reg;
      cyc_cnt_next = cyc_cnt_reg;
      err_set      = 2'b00;
      case (state_reg)
         ST_IDLE: begin
            // stop beats a same-cycle start; a rejected start flags err[0]
            if (start && !stop) begin
               if (bad_freq) begin
                  err_set[0] = 1'b1;
               end else begin
                  state_next   = ST_RUN;
                  acc_next     = '0;
                  cyc_cnt_next = '0;
                  freq_l_next  = freq_word;
                  bc_l_next    = burst_cycles;
               end
            end
         end
         ST_RUN, ST_DRAIN: begin
            if (start) begin
               err_set[1] = 1'b1;
            end
            if (step) begin
               acc_next = acc_sum[PHASE_W-1:0];
               if (wrap) begin
                  cyc_cnt_next = cyc_inc;
               end
            end
            if ((state_reg == ST_RUN) && stop) begin
               state_next = ST_DRAIN;
            end
            // A wrap closes the current carrier cycle. A stop arriving on the
            // wrapping sample counts that cycle as the one to finish.
            if (step && wrap) begin
               if ((state_reg == ST_DRAIN) || stop) begin
                  state_next = ST_IDLE;
               end else if ((bc_l_reg != 24'd0) && (cyc_inc == bc_l_reg)) begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      err_next = err_clr ? 2'b00 : (err_reg | err_set);
   end

   // Control registers.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         acc_reg     <= '0;
         freq_l_reg  <= '0;
         bc_l_reg    <= '0;
         cyc_cnt_reg <= '0;
         err_reg     <= 2'b00;
      end else begin
         state_reg   <= state_next;
         acc_reg     <= acc_next;
         freq_l_reg  <= freq_l_next;
         bc_l_reg    <= bc_l_next;
         cyc_cnt_reg <= cyc_cnt_next;
         err_reg     <= err_next;
      end
   end

   assign busy = active;
   assign err  = err_reg;

   // ------------------------------------------------------------------
   // Lookup phase (quadrant + LUT address), optionally dithered
   // ------------------------------------------------------------------
   logic [LUT_AW+1:0] lk_top;

`ifdef PHASE_DITHER_EN
   logic [15:0]        lfsr_reg;
   logic               lfsr_fb;
   logic [PHASE_W-1:0] dither_val;
   logic [PHASE_W-1:0] dith_phase;

   // Taps 16,14,13,11 of the shift-right Fibonacci form.
   assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

   // Dither source advances once per sample strobe.
   always_ff @(posedge clk1) begin
      if (rst) begin
         lfsr_reg <= 16'hACE1;
      end else if (sample_en) begin
         lfsr_reg <= {lfsr_fb, lfsr_reg[15:1]};
      end
   end

   // Align the LFSR so its top bit sits just below the LUT address.
   generate
      if (TRUNC_W >= 16) begin : g_dith_wide
         assign dither_val = PHASE_W'(lfsr_reg) << (TRUNC_W - 16);
      end else if (TRUNC_W > 0) begin : g_dith_narrow
         assign dither_val = PHASE_W'(lfsr_reg >> (16 - TRUNC_W));
      end else begin : g_dith_none
         assign dither_val = PHASE_W'(lfsr_reg & 16'h0000);
      end
   endgenerate

   assign dith_phase = acc_reg + dither_val;
   assign lk_top     = (LUT_AW + 2)'(dith_phase >> TRUNC_W);
`else
   assign lk_top = (LUT_AW + 2)'(acc_reg >> TRUNC_W);
`endif

   // ------------------------------------------------------------------
   // Stage 1: address register (phase before this sample's increment)
   // ------------------------------------------------------------------
   logic              s1_vld_reg;
   logic [1:0]        s1_quad_reg;
   logic [LUT_AW-1:0] s1_addr_reg;
   logic              s2_vld_reg;
   logic              iq_vld_reg;

   // Capture quadrant/address for every accepted sample.
   always_ff @(posedge clk1) begin
      if (rst) begin
         s1_vld_reg  <= 1'b0;
         s1_quad_reg <= 2'b00;
         s1_addr_reg <= '0;
      end else begin
         s1_vld_reg <= step;
         if (step) begin
            s1_quad_reg <= lk_top[LUT_AW+1:LUT_AW];
            s1_addr_reg <= lk_top[LUT_AW-1:0];
         end
      end
   end

   // Valid pipeline for stages 2 and 3.
   always_ff @(posedge clk1) begin
      if (rst) begin
         s2_vld_reg <= 1'b0;
         iq_vld_reg <= 1'b0;
      end else begin
         s2_vld_reg <= s1_vld_reg;
         iq_vld_reg <= s2_vld_reg;
      end
   end

   // ------------------------------------------------------------------
   // Stages 2-3 per lane: lane 0 = Q (phase), lane 1 = I (phase + 90 deg)
   // ------------------------------------------------------------------
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [1:0]        quad;
         logic [LUT_AW-1:0] rd_addr;
         logic [15:0]       rom_reg;
         logic              neg_reg;
         logic [15:0]       pcm_reg;

         assign quad    = s1_quad_reg + 2'(gi);
         assign rd_addr = quad[0] ? ~s1_addr_reg : s1_addr_reg;

         // ROM read with registered output; sign decided by quadrant.
         always_ff @(posedge clk1) begin
            rom_reg <= lut_rom[rd_addr];
            neg_reg <= quad[1];
         end

         // Apply sign and hold the result until the next sample.
         always_ff @(posedge clk1) begin
            if (rst) begin
               pcm_reg <= 16'h0000;
            end else if (s2_vld_reg) begin
               pcm_reg <= neg_reg ? (16'h0000 - rom_reg) : rom_reg;
            end
         end
      end
   endgenerate

   assign qpcm_out    = g_lane[0].pcm_reg;
   assign ipcm_out    = g_lane[1].pcm_reg;
   assign iqpcm_valid = iq_vld_reg;

   // ------------------------------------------------------------------
   // Stages 4-5: amplitude scaling of I, then saturation
   // ------------------------------------------------------------------
   logic signed [32:0] prod;
   logic signed [17:0] mul_reg;
   logic               mul_vld_reg;
   logic [15:0]        da_reg;
   logic               da_vld_reg;

   assign prod = $signed(ipcm_out) * $signed({1'b0, amp});

   // Scale by Q1.15 amplitude (arithmetic shift floors toward -inf).
   always_ff @(posedge clk1) begin
      if (rst) begin
         mul_reg     <= '0;
         mul_vld_reg <= 1'b0;
      end else begin
         mul_vld_reg <= iq_vld_reg;
         if (iq_vld_reg) begin
            mul_reg <= 18'(prod >>> 15);
         end
      end
   end

   // Clamp the scaled value into 16-bit signed range and hold it.
   always_ff @(posedge clk1) begin
      if (rst) begin
         da_reg     <= 16'h0000;
         da_vld_reg <= 1'b0;
      end else begin
         da_vld_reg <= mul_vld_reg;
         if (mul_vld_reg) begin
            if (mul_reg > 18'sd32767) begin
               da_reg <= 16'h7FFF;
            end else if (mul_reg < -18'sd32768) begin
               da_reg <= 16'h8000;
            end else begin
               da_reg <= mul_reg[15:0];
            end
         end
      end
   end

   assign da_pcm_out   = da_reg;
   assign da_pcm_valid = da_vld_reg;

endmodule

// File: tb/tb_iq_tx_nco.sv
// tb_iq_tx_nco: directed + randomized bench for iq_tx_nco with a
// behavioural reference model (sine from $sin, burst rules as arithmetic).
module tb_iq_tx_nco;

   localparam int  PW = 32;
   localparam int  AW = 8;
   localparam real PI = 3.14159265358979323846;

   logic          clk1 = 1'b0;
   logic          rst = 1'b1;
   logic          sample_en = 1'b0;
   logic [PW-1:0] freq_word = '0;
   logic [15:0]   amp = 16'h8000;
   logic [23:0]   burst_cycles = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          err_clr = 1'b0;
   logic [15:0]   ipcm_out, qpcm_out, da_pcm_out;
   logic          iqpcm_valid, da_pcm_valid, busy;
   logic [1:0]    err;

   always #5 clk1 = ~clk1;

   iq_tx_nco #(.PHASE_W(PW), .LUT_AW(AW)) dut (
      .clk1         (clk1),
      .rst          (rst),
      .sample_en    (sample_en),
      .freq_word    (freq_word),
      .amp          (amp),
      .burst_cycles (burst_cycles),
      .start        (start),
      .stop         (stop),
      .ipcm_out     (ipcm_out),
      .qpcm_out     (qpcm_out),
      .iqpcm_valid  (iqpcm_valid),
      .da_pcm_out   (da_pcm_out),
      .da_pcm_valid (da_pcm_valid),
      .busy         (busy),
      .err_clr      (err_clr),
      .err          (err)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   typedef struct { int due; logic [15:0] i; logic [15:0] q; } iq_t;
   typedef struct { int due; logic [15:0] d; } da_t;
   iq_t             q_iq[$];
   da_t             q_da[$];
   int              m_state = 0;          // 0 idle, 1 run, 2 drain
   longint unsigned m_acc = 0;
   longint unsigned m_fw = 0;
   int unsigned     m_bc = 0;
   int unsigned     m_cnt = 0;
   logic [1:0]      m_err = 2'b00;
   logic [15:0]     h_i = 16'h0, h_q = 16'h0, h_d = 16'h0;
   int              cyc = 0;

   // observation records for directed checks
   int          pulses = 0;
   logic [15:0] obs_q[$];
   logic [15:0] obs_i[$];
   logic [15:0] obs_d[$];
   int          first_iq_cyc = -1;
   int          first_da_cyc = -1;
   int          drive_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Signed sine of a full-circle phase, quantised to 2^(AW+2) bins.
   function automatic logic [15:0] ref_wave(input longint unsigned ph);
      longint unsigned j;
      real s;
      int  mag;
      j   = (ph >> (PW - 2 - AW)) & 64'd1023;
      s   = $sin(2.0 * PI * (real'(j) + 0.5) / 1024.0);
      mag = $rtoi(((s < 0.0) ? -s : s) * 32767.0 + 0.5);
      return (s < 0.0) ? 16'(-mag) : 16'(mag);
   endfunction

   function automatic logic [15:0] ref_da(input logic [15:0] iv, input logic [15:0] a);
      real r;
      int  d;
      r = $floor(real'($signed(iv)) * real'(a) / 32768.0);
      d = $rtoi(r);
      if (d > 32767)  d = 32767;
      if (d < -32768) d = -32768;
      return 16'(d);
   endfunction

   task automatic model_edge();
      logic [1:0] set;
      logic       wrapped;
      iq_t        e;
      da_t        f;
      if (rst) begin
         m_state = 0; m_acc = 0; m_cnt = 0; m_err = 2'b00; m_fw = 0; m_bc = 0;
         q_iq.delete(); q_da.delete();
         h_i = 16'h0; h_q = 16'h0; h_d = 16'h0;
         return;
      end
      set = 2'b00;
      wrapped = 1'b0;
      if (m_state == 0) begin
         if (start && !stop) begin
            if (freq_word == 0 || freq_word[PW-1]) set[0] = 1'b1;
            else begin
               m_state = 1; m_fw = 64'(freq_word); m_bc = 32'(burst_cycles);
               m_acc = 0; m_cnt = 0;
            end
         end
      end else begin
         if (start) set[1] = 1'b1;
         if (sample_en) begin
            e.due = cyc + 2;
            e.q   = ref_wave(m_acc);
            e.i   = ref_wave(m_acc + 64'h4000_0000);
            q_iq.push_back(e);
            f.due = cyc + 4;
            f.d   = ref_da(e.i, amp);
            q_da.push_back(f);
            m_acc = m_acc + m_fw;
            if (m_acc >= 64'h1_0000_0000) begin
               m_acc = m_acc - 64'h1_0000_0000;
               m_cnt++;
               wrapped = 1'b1;
            end
         end
         if (wrapped && (m_state == 2 || stop || (m_bc != 0 && m_cnt == m_bc))) m_state = 0;
         else if (m_state == 1 && stop) m_state = 2;
      end
      m_err = err_clr ? 2'b00 : (m_err | set);
   endtask

   task automatic check_outputs();
      logic ev, dv;
      ev = (q_iq.size() > 0) && (q_iq[0].due == cyc);
      if (ev) begin h_i = q_iq[0].i; h_q = q_iq[0].q; void'(q_iq.pop_front()); end
      dv = (q_da.size() > 0) && (q_da[0].due == cyc);
      if (dv) begin h_d = q_da[0].d; void'(q_da.pop_front()); end
      chk("iqpcm_valid", 32'(iqpcm_valid), 32'(ev));
      chk("ipcm_out", 32'(ipcm_out), 32'(h_i));
      chk("qpcm_out", 32'(qpcm_out), 32'(h_q));
      chk("da_pcm_valid", 32'(da_pcm_valid), 32'(dv));
      chk("da_pcm_out", 32'(da_pcm_out), 32'(h_d));
      chk("busy", 32'(busy), 32'(m_state != 0));
      chk("err", 32'(err), 32'(m_err));
      if (iqpcm_valid === 1'b1) begin
         pulses++;
         obs_q.push_back(qpcm_out);
         obs_i.push_back(ipcm_out);
         if (first_iq_cyc < 0) first_iq_cyc = cyc;
      end
      if (da_pcm_valid === 1'b1) begin
         obs_d.push_back(da_pcm_out);
         if (first_da_cyc < 0) first_da_cyc = cyc;
      end
   endtask

   // One clk1 cycle: drive at negedge, model at posedge, check at next negedge.
   task automatic step(input logic se, input logic st, input logic sp,
                       input logic ec, input logic rs);
      sample_en = se; start = st; stop = sp; err_clr = ec; rst = rs;
      drive_cyc = cyc;
      @(posedge clk1);
      cyc++;
      model_edge();
      @(negedge clk1);
      sample_en = 1'b0; start = 1'b0; stop = 1'b0; err_clr = 1'b0; rst = 1'b0;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic samples(input int n, input int gap);
      for (int k = 0; k < n; k++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         idle(gap - 1);
      end
   endtask

   task automatic clear_obs();
      pulses = 0; obs_q.delete(); obs_i.delete(); obs_d.delete();
      first_iq_cyc = -1; first_da_cyc = -1;
   endtask

   logic [15:0] q_pat[4]  = '{16'h0065, 16'h7FFF, 16'hFF9B, 16'h8001};
   logic [15:0] i_pat[4]  = '{16'h7FFF, 16'hFF9B, 16'h8001, 16'h0065};
   logic [15:0] d_half[4] = '{16'h3FFF, 16'hFFCD, 16'hC000, 16'h0032};

   initial begin
      int se_cyc;
      int stop_at;
      @(negedge clk1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ipcm", 32'(ipcm_out), 32'd0);

      // 1) three-cycle burst at quarter-rate carrier, full amplitude
      freq_word = 32'h4000_0000; burst_cycles = 24'd3; amp = 16'h8000;
      clear_obs();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      samples(12, 8);
      chk("burst1_busy_after", 32'(busy), 32'd0);
      samples(2, 8);
      chk("burst1_pulses", 32'(pulses), 32'd12);
      for (int k = 0; k < 12; k++) begin
         if (k < obs_q.size()) begin
            chk("burst1_q", 32'(obs_q[k]), 32'(q_pat[k%4]));
            chk("burst1_i", 32'(obs_i[k]), 32'(i_pat[k%4]));
         end
         if (k < obs_d.size()) chk("burst1_da", 32'(obs_d[k]), 32'(i_pat[k%4]));
      end

      // 2) half amplitude and output latencies
      amp = 16'h4000;
      clear_obs();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      se_cyc = drive_cyc;
      idle(7);
      samples(11, 8);
      chk("iq_latency", 32'(first_iq_cyc - se_cyc), 32'd3);
      chk("da_latency", 32'(first_da_cyc - se_cyc), 32'd5);
      for (int k = 0; k < 12; k++)
         if (k < obs_d.size()) chk("burst2_da", 32'(obs_d[k]), 32'(d_half[k%4]));

      // 3) continuous mode, stop after the 6th sample
      amp = 16'h8000; burst_cycles = 24'd0;
      clear_obs();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      samples(6, 8);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      samples(4, 8);
      chk("cont_pulses", 32'(pulses), 32'd8);
      chk("cont_busy", 32'(busy), 32'd0);
      chk("cont_err", 32'(err), 32'd0);

      // 4) rejected starts and err handling
      freq_word = 32'h8000_0000;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("nyq_busy", 32'(busy), 32'd0);
      chk("nyq_err", 32'(err), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("errclr", 32'(err), 32'd0);
      freq_word = 32'h0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("zero_fw_err", 32'(err), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("clr_priority", 32'(err), 32'd0);
      freq_word = 32'h4000_0000;
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("start_stop_idle", 32'(busy), 32'd0);

      // 5) start while busy
      burst_cycles = 24'd2;
      clear_obs();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      samples(1, 8);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("busy_start_err", 32'(err), 32'd2);
      samples(9, 8);
      chk("busy_start_pulses", 32'(pulses), 32'd8);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // 6) reset mid-burst, then restart from phase 0
      burst_cycles = 24'd3;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      samples(4, 8);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_qpcm", 32'(qpcm_out), 32'd0);
      chk("rst_da", 32'(da_pcm_out), 32'd0);
      idle(8);
      clear_obs();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      samples(1, 8);
      chk("restart_pulses", 32'(pulses), 32'd1);
      if (obs_q.size() > 0) chk("restart_q0", 32'(obs_q[0]), 32'h0065);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // 7) back-to-back samples at eighth-rate carrier
      freq_word = 32'h2000_0000; burst_cycles = 24'd2;
      clear_obs();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      samples(18, 1);
      idle(6);
      chk("b2b_pulses", 32'(pulses), 32'd16);

      // 8) randomized bursts with random gaps, stops, starts and clears
      for (int b = 0; b < 16; b++) begin
         amp = 16'($urandom);
         freq_word = $urandom_range(32'h7FFF_FFFF, 32'h0600_0000);
         if ($urandom % 8 == 0) freq_word = 32'h8000_0000 | 32'($urandom);
         burst_cycles = 24'($urandom_range(3, 0));
         stop_at = (burst_cycles == 0) ? 40 : 1000;
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         for (int n = 0; n < 300 && m_state != 0; n++) begin
            freq_word    = $urandom;
            burst_cycles = 24'($urandom);
            step(1'($urandom % 2), 1'($urandom % 50 == 0),
                 1'(n == stop_at || $urandom % 40 == 0),
                 1'($urandom % 40 == 0), 1'b0);
         end
         if (m_state != 0) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         idle(6);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
